// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR widths and the round/shift/saturate helper
package fir_pkg;

    localparam int FIR_IN_W  = 32;
    localparam int FIR_OUT_W = 16;
    localparam int RS_W      = 64;

    typedef struct packed {
        logic signed [RS_W-1:0] value;
        logic                   sat;
    } rs_t;

    // Operates on a 64-bit sign-extended sample so the rounding add can never wrap.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] x,
                                      input int shift,
                                      input int out_w);
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t res;
        r = x;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b0;
        if (r > hi) begin
            r       = hi;
            res.sat = 1'b1;
        end else if (r < lo) begin
            r       = lo;
            res.sat = 1'b1;
        end
        res.value = r;
        return res;
    endfunction

endpackage

// File: rtl/fir_sfifo.sv
// rtl/fir_sfifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module fir_sfifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is legal only when the head leaves on the same edge.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_collector.sv
// rtl/fir_out_collector.sv - conditions FIR samples, buffers them and tracks drop/clip statistics
module fir_out_collector
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [IN_W-1:0]     y_in,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 sat_cnt,
    input  logic                       clr_stat
);

    rs_t                     rs;
    logic                    s1_valid;
    logic                    s1_sat;
    logic signed [OUT_W-1:0] s1_data;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    sat_event;

    always_comb begin
        rs = round_sat(64'(y_in), SHIFT, OUT_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= OUT_W'(rs.value);
                s1_sat  <= rs.sat;
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!fifo_full || pop);
    assign drop      = s1_valid && fifo_full && !pop;
    assign sat_event = s1_valid && s1_sat;

    fir_sfifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (s1_data),
        .rd_en   (pop),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (count)
    );

    // A set/increment on the same edge as clr_stat takes priority over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            sat_cnt  <= 8'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_stat) begin
                overflow <= 1'b0;
            end
            if (sat_event) begin
                if (clr_stat) begin
                    sat_cnt <= 8'd1;
                end else if (sat_cnt != 8'd255) begin
                    sat_cnt <= sat_cnt + 8'd1;
                end
            end else if (clr_stat) begin
                sat_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_collector.sv
// tb/tb_fir_out_collector.sv - randomized and directed bench for fir_out_collector
module tb_fir_out_collector;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [IN_W-1:0]  y_in;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_ready;
    logic [CW-1:0]           count;
    logic                    overflow;
    logic [7:0]              sat_cnt;
    logic                    clr_stat;

    int n_checks = 0;
    int n_pass   = 0;

    bit m_s1_v;
    int m_s1_d;
    bit m_s1_s;
    int mq[$];
    bit m_ovf;
    int m_sat;
    int got[$];

    always #5 clk = ~clk;

    fir_out_collector #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .sat_cnt   (sat_cnt),
        .clr_stat  (clr_stat)
    );

    // Floor-division rounding and clipping, straight from the arithmetic definition.
    function automatic void cond(input longint x, output int v, output bit s);
        longint d;
        longint t;
        longint q;
        longint hi;
        longint lo;
        d  = longint'(1) << SHIFT;
        t  = x + ((SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : longint'(0));
        q  = t / d;
        if (t < 0 && q * d != t) q = q - 1;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        s  = 1'b0;
        if (q > hi) begin q = hi; s = 1'b1; end
        if (q < lo) begin q = lo; s = 1'b1; end
        v = int'(q);
    endfunction

    task automatic model_clear();
        m_s1_v = 0;
        m_s1_d = 0;
        m_s1_s = 0;
        mq.delete();
        m_ovf  = 0;
        m_sat  = 0;
    endtask

    task automatic model_edge(input bit iv, input int y, input bit rdy, input bit clr);
        bit pop;
        bit ovf_ev;
        bit sat_ev;
        pop    = (mq.size() > 0) && rdy;
        ovf_ev = 0;
        sat_ev = m_s1_v && m_s1_s;
        if (pop) void'(mq.pop_front());
        if (m_s1_v) begin
            if (mq.size() < DEPTH) mq.push_back(m_s1_d);
            else ovf_ev = 1;
        end
        if (clr) begin m_ovf = 0; m_sat = 0; end
        if (ovf_ev) m_ovf = 1;
        if (sat_ev && m_sat < 255) m_sat = m_sat + 1;
        m_s1_v = iv;
        if (iv) cond(longint'(y), m_s1_d, m_s1_s);
    endtask

    task automatic step(input bit iv, input int y, input bit rdy, input bit clr);
        in_valid  = iv;
        y_in      = y;
        out_ready = rdy;
        clr_stat  = clr;
        if (out_valid && out_ready) got.push_back(int'(out_data));
        @(posedge clk);
        model_edge(iv, y, rdy, clr);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        clr_stat  = 1'b0;
        model_clear();
        got.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else n_pass++;
        n_checks++; if (sat_cnt !== 8'd0) $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_rounding();
        int exp_v[4] = '{2, -1, 0, 1};
        do_reset();
        step(1, 384, 1, 0);
        step(1, -384, 1, 0);
        step(1, 127, 1, 0);
        step(1, 128, 1, 0);
        repeat (4) step(0, 0, 1, 0);
        n_checks++; if (got.size() != 4) $display("FAIL round_count got %0d want 4", got.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] != exp_v[i]) $display("FAIL round_value[%0d] got %0d want %0d", i, got[i], exp_v[i]);
            else n_pass++;
        end
        n_checks++; if (sat_cnt !== 8'd0) $display("FAIL round_sat_cnt got %0d want 0", sat_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        step(1, 32'h7FFF_FFFF, 1, 0);
        step(1, 32'sh8000_0000, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        n_checks++; if (got.size() != 2) $display("FAIL sat_count got %0d want 2", got.size()); else n_pass++;
        if (got.size() == 2) begin
            n_checks++; if (got[0] != 32767) $display("FAIL sat_high got %0d want 32767", got[0]); else n_pass++;
            n_checks++; if (got[1] != -32768) $display("FAIL sat_low got %0d want -32768", got[1]); else n_pass++;
        end
        n_checks++; if (sat_cnt !== 8'd2) $display("FAIL sat_cnt got %0d want 2", sat_cnt); else n_pass++;
        step(0, 0, 1, 1);
        n_checks++; if (sat_cnt !== 8'd0) $display("FAIL sat_clear got %0d want 0", sat_cnt); else n_pass++;
    endtask

    task automatic test_sat_hold();
        do_reset();
        repeat (270) step(1, -32'sd2000000000, 1, 0);
        repeat (2) step(0, 0, 1, 0);
        n_checks++; if (sat_cnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", sat_cnt); else n_pass++;
    endtask

    task automatic test_streaming();
        int ins[5] = '{256, 512, 768, 1024, 0};
        int exp_v[5] = '{1, 2, 3, 4, 0};
        int first_v;
        int max_cnt;
        do_reset();
        first_v = -1;
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(i < 5, (i < 5) ? ins[i] : 0, 1, 0);
            if (out_valid && first_v < 0) first_v = i;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        n_checks++; if (first_v != 1) $display("FAIL stream_latency got edge %0d want edge 1", first_v); else n_pass++;
        n_checks++; if (max_cnt > 1) $display("FAIL stream_max_count got %0d want <=1", max_cnt); else n_pass++;
        n_checks++; if (got.size() != 5) $display("FAIL stream_count got %0d want 5", got.size()); else n_pass++;
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] != exp_v[i]) $display("FAIL stream_value[%0d] got %0d want %0d", i, got[i], exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int n = 1; n <= 10; n++) step(1, 256 * n, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        n_checks++; if (count !== CW'(8)) $display("FAIL ovf_count got %0d want 8", count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else n_pass++;
        repeat (10) step(0, 0, 1, 0);
        n_checks++; if (got.size() != 8) $display("FAIL ovf_drain_count got %0d want 8", got.size()); else n_pass++;
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] != i + 1) $display("FAIL ovf_drain[%0d] got %0d want %0d", i, got[i], i + 1);
            else n_pass++;
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_empty got %0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int n = 1; n <= 8; n++) step(1, 256 * n, 0, 0);
        step(0, 0, 0, 0);
        n_checks++; if (count !== CW'(8)) $display("FAIL fullpop_prefill got %0d want 8", count); else n_pass++;
        step(1, 256 * 9, 0, 0);
        step(0, 0, 1, 0);
        n_checks++; if (count !== CW'(8)) $display("FAIL fullpop_count got %0d want 8", count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow got %0b want 0", overflow); else n_pass++;
        repeat (10) step(0, 0, 1, 0);
        n_checks++; if (got.size() != 9) $display("FAIL fullpop_total got %0d want 9", got.size()); else n_pass++;
        if (got.size() == 9) begin
            n_checks++; if (got[8] != 9) $display("FAIL fullpop_last got %0d want 9", got[8]); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) step(1, 32'h7FFF_FFFF, 0, 0);
        for (int n = 1; n <= 7; n++) step(1, 256 * n, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        n_checks++; if (count !== CW'(5)) $display("FAIL arst_pre_count got %0d want 5", count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL arst_pre_overflow got %0b want 1", overflow); else n_pass++;
        n_checks++; if (sat_cnt !== 8'd3) $display("FAIL arst_pre_sat got %0d want 3", sat_cnt); else n_pass++;
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL arst_count got %0d want 0", count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL arst_overflow got %0b want 0", overflow); else n_pass++;
        n_checks++; if (sat_cnt !== 8'd0) $display("FAIL arst_sat got %0d want 0", sat_cnt); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL arst_out_data got %0d want 0", out_data); else n_pass++;
        model_clear();
        got.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1, 256, 1, 0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_lat1 got %0b want 0", out_valid); else n_pass++;
        step(0, 0, 1, 0);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL arst_lat2 got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'sd1) $display("FAIL arst_data got %0d want 1", out_data); else n_pass++;
    endtask

    task automatic test_random();
        int y;
        logic signed [OUT_W-1:0] exp_d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) y = int'($urandom());
            else y = int'($urandom_range(0, 1 << 24)) - (1 << 23);
            step($urandom_range(0, 9) < 7, y, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            n_checks++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, out_valid, mq.size() > 0); else n_pass++;
            n_checks++; if (count !== CW'(mq.size())) $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, mq.size()); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_overflow cyc %0d got %0b want %0b", i, overflow, m_ovf); else n_pass++;
            n_checks++; if (sat_cnt !== 8'(m_sat)) $display("FAIL rnd_sat cyc %0d got %0d want %0d", i, sat_cnt, m_sat); else n_pass++;
            if (mq.size() > 0) begin
                exp_d = OUT_W'(mq[0]);
                n_checks++; if (out_data !== exp_d) $display("FAIL rnd_data cyc %0d got %0d want %0d", i, out_data, exp_d); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_sat_hold();
        test_streaming();
        test_overflow();
        test_full_pop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
